// File: rtl/counter_seq_pkg.sv
// Shared state encoding for the counter sequencer and its datapath.
package counter_seq_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2,
        S_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/load_counter.sv
// Up-counter with synchronous clear, increment enable and terminal compare.
module load_counter #(
    parameter int BITS = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            clear_i,
    input  logic            inc_i,
    input  logic [BITS-1:0] limit_i,
    output logic [BITS-1:0] count_o,
    output logic            at_limit_o
);

    logic [BITS-1:0] count_q;
    logic [BITS-1:0] count_d;

    // Clear wins over increment; the wrap to zero is always an explicit clear.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (inc_i) begin
            count_d = count_q + BITS'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o    = count_q;
    assign at_limit_o = (count_q == limit_i);

endmodule

// File: rtl/counter_sequencer.sv
// Control FSM sequencing a load_counter: start/stop/pause, one-shot or periodic,
// tick-gated counting with shadowed limit and mode.
module counter_sequencer
    import counter_seq_pkg::*;
#(
    parameter int BITS = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               stop,
    input  logic               pause,
    input  logic               mode,
    input  logic               tick,
    input  logic [BITS-1:0]    limit,
    output logic [BITS-1:0]    count,
    output logic               busy,
    output logic               done,
    output logic               tc,
    output logic [STATE_W-1:0] state
);

    state_e          state_q;
    logic [BITS-1:0] limit_q;
    logic            mode_q;
    logic            busy_q;
    logic            done_q;
    logic            tc_q;

    logic            at_limit;
    logic            run_tick;
    logic            cnt_clear;
    logic            cnt_inc;

    // A tick only counts in RUN when no higher-priority request is present.
    assign run_tick  = (state_q == S_RUN) && !stop && !start && !pause && tick;
    assign cnt_clear = stop || start || (run_tick && at_limit && mode_q);
    assign cnt_inc   = run_tick && !at_limit;

    load_counter #(
        .BITS(BITS)
    ) u_counter (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear_i   (cnt_clear),
        .inc_i     (cnt_inc),
        .limit_i   (limit_q),
        .count_o   (count),
        .at_limit_o(at_limit)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            limit_q <= '0;
            mode_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            tc_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            tc_q   <= 1'b0;
            if (stop && state_q != S_IDLE) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
            end else if (start) begin
                state_q <= S_RUN;
                busy_q  <= 1'b1;
                limit_q <= limit;
                mode_q  <= mode;
            end else begin
                case (state_q)
                    S_RUN: begin
                        if (pause) begin
                            state_q <= S_HOLD;
                        end else if (tick && at_limit) begin
                            if (mode_q) begin
                                tc_q <= 1'b1;
                            end else begin
                                state_q <= S_DONE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end
                        end
                    end
                    S_HOLD: begin
                        if (!pause) begin
                            state_q <= S_RUN;
                        end
                    end
                    S_IDLE, S_DONE: begin
                        state_q <= state_q;
                    end
                    default: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign tc    = tc_q;
    assign state = state_q;

endmodule
